// File: rtl/saes_enc_ctrl_if.sv
// Host-side handshake bundle for the S-AES encryption controller.
// The master drives keys and blocks and consumes results; the slave is the controller.
`timescale 1ns/1ps
interface saes_enc_ctrl_if;
  logic        key_valid;
  logic [15:0] key_in;
  logic        key_ready;
  logic        in_valid;
  logic [15:0] plain_in;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cipher_out;
  logic        keys_ok;

  modport master (
    output key_valid, key_in, in_valid, plain_in, out_ready,
    input  key_ready, in_ready, out_valid, cipher_out, keys_ok
  );

  modport slave (
    input  key_valid, key_in, in_valid, plain_in, out_ready,
    output key_ready, in_ready, out_valid, cipher_out, keys_ok
  );
endinterface

// File: rtl/saes_enc_ctrl.sv
// S-AES encryption controller: two-cycle key expansion on a shared sbox pair, then
// one block per three cycles through a combinational S-AES round datapath.
`timescale 1ns/1ps
module saes_enc_ctrl #(
  parameter logic [7:0] RCON1 = 8'h80,
  parameter logic [7:0] RCON2 = 8'h30
) (
  input logic            clk,
  input logic            rst_n,
  saes_enc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StKexp1, StKexp2, StReady, StCalc, StHold} state_e;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    case (n)
      4'h0: s = 4'h9;  4'h1: s = 4'h4;  4'h2: s = 4'hA;  4'h3: s = 4'hB;
      4'h4: s = 4'hD;  4'h5: s = 4'h1;  4'h6: s = 4'h8;  4'h7: s = 4'h5;
      4'h8: s = 4'h6;  4'h9: s = 4'h2;  4'hA: s = 4'h0;  4'hB: s = 4'h3;
      4'hC: s = 4'hC;  4'hD: s = 4'hE;  4'hE: s = 4'hF;  4'hF: s = 4'h7;
    endcase
    return s;
  endfunction

  function automatic logic [15:0] sub16(input logic [15:0] s);
    return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
  endfunction

  // Nibble order is s00, s10, s01, s11; shifting row 1 swaps s10 and s11.
  function automatic logic [15:0] shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  // GF(2^4) modulo x^4 + x + 1
  function automatic logic [3:0] xtime(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [3:0] mul4(input logic [3:0] a);
    return xtime(xtime(a));
  endfunction

  function automatic logic [15:0] mix_cols(input logic [15:0] s);
    return {s[15:12] ^ mul4(s[11:8]), mul4(s[15:12]) ^ s[11:8],
            s[7:4] ^ mul4(s[3:0]),   mul4(s[7:4]) ^ s[3:0]};
  endfunction

  function automatic logic [15:0] encrypt(input logic [15:0] pt, input logic [15:0] k0,
                                          input logic [15:0] k1, input logic [15:0] k2);
    logic [15:0] r;
    r = shift_rows(sub16(pt ^ k0));
    r = mix_cols(r) ^ k1;
    return shift_rows(sub16(r)) ^ k2;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] key0_q, key0_d, key1_q, key1_d, key2_q, key2_d;
  logic [15:0] plain_q, plain_d, cipher_q, cipher_d;
  logic        keys_ok_q, keys_ok_d;

  logic        key_ready, in_ready, key_fire, blk_fire;
  logic [15:0] exp_src, exp_word;
  logic [7:0]  exp_rcon, exp_sub, exp_hi;
  logic [15:0] enc_out;

  assign key_ready = (state_q == StIdle) || (state_q == StReady);
  // A pending key always beats a pending block.
  assign in_ready  = (state_q == StReady) && !bus.key_valid;
  assign key_fire  = bus.key_valid && key_ready;
  assign blk_fire  = bus.in_valid && in_ready;

  // The sbox pair sees (w0,w1) in KEXP1 and (w2,w3) in KEXP2.
  assign exp_src  = (state_q == StKexp2) ? key1_q : key0_q;
  assign exp_rcon = (state_q == StKexp2) ? RCON2 : RCON1;
  assign exp_sub  = {sbox(exp_src[3:0]), sbox(exp_src[7:4])};
  assign exp_hi   = exp_src[15:8] ^ exp_rcon ^ exp_sub;
  assign exp_word = {exp_hi, exp_hi ^ exp_src[7:0]};

  assign enc_out = encrypt(plain_q, key0_q, key1_q, key2_q);

  always_comb begin
    state_d   = state_q;
    key0_d    = key0_q;
    key1_d    = key1_q;
    key2_d    = key2_q;
    plain_d   = plain_q;
    cipher_d  = cipher_q;
    keys_ok_d = keys_ok_q;
    unique case (state_q)
      StIdle: begin
        if (key_fire) begin
          key0_d    = bus.key_in;
          keys_ok_d = 1'b0;
          state_d   = StKexp1;
        end
      end
      StKexp1: begin
        key1_d  = exp_word;
        state_d = StKexp2;
      end
      StKexp2: begin
        key2_d    = exp_word;
        keys_ok_d = 1'b1;
        state_d   = StReady;
      end
      StReady: begin
        if (key_fire) begin
          key0_d    = bus.key_in;
          keys_ok_d = 1'b0;
          state_d   = StKexp1;
        end else if (blk_fire) begin
          plain_d = bus.plain_in;
          state_d = StCalc;
        end
      end
      StCalc: begin
        cipher_d = enc_out;
        state_d  = StHold;
      end
      StHold: begin
        if (bus.out_ready) state_d = StReady;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      key0_q    <= '0;
      key1_q    <= '0;
      key2_q    <= '0;
      plain_q   <= '0;
      cipher_q  <= '0;
      keys_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key0_q    <= key0_d;
      key1_q    <= key1_d;
      key2_q    <= key2_d;
      plain_q   <= plain_d;
      cipher_q  <= cipher_d;
      keys_ok_q <= keys_ok_d;
    end
  end

  assign bus.key_ready  = key_ready;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == StHold);
  assign bus.cipher_out = cipher_q;
  assign bus.keys_ok    = keys_ok_q;

endmodule

// File: tb/tb_saes_enc_ctrl.sv
// Directed bench for saes_enc_ctrl: known S-AES vector, backpressure, async reset,
// key/block collision and back-to-back blocks against an independent reference model.
`timescale 1ns/1ps
module tb_saes_enc_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;

  saes_enc_ctrl_if bus();

  saes_enc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference model, written from the S-AES definition.
  function automatic logic [3:0] ref_sbox(input logic [3:0] n);
    logic [63:0] tbl;
    tbl = 64'h7FEC_3026_581D_BA49;
    return tbl[4*n +: 4];
  endfunction

  function automatic logic [3:0] ref_gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [15:0] ref_round_sub_shift(input logic [15:0] s);
    logic [3:0] n [4];
    for (int i = 0; i < 4; i++) n[i] = ref_sbox(s[15-4*i -: 4]);
    return {n[0], n[3], n[2], n[1]};
  endfunction

  function automatic logic [7:0] ref_g(input logic [7:0] w, input logic [7:0] rc);
    return rc ^ {ref_sbox(w[3:0]), ref_sbox(w[7:4])};
  endfunction

  function automatic logic [15:0] ref_enc(input logic [15:0] pt, input logic [15:0] k);
    logic [7:0]  w2, w3, w4, w5;
    logic [15:0] s;
    logic [3:0]  a, b, c, d;
    w2 = k[15:8] ^ ref_g(k[7:0], 8'h80);
    w3 = w2 ^ k[7:0];
    w4 = w2 ^ ref_g(w3, 8'h30);
    w5 = w4 ^ w3;
    s = ref_round_sub_shift(pt ^ k);
    a = s[15:12]; b = s[11:8]; c = s[7:4]; d = s[3:0];
    s = {a ^ ref_gmul(4'h4, b), ref_gmul(4'h4, a) ^ b,
         c ^ ref_gmul(4'h4, d), ref_gmul(4'h4, c) ^ d};
    s = s ^ {w2, w3};
    return ref_round_sub_shift(s) ^ {w4, w5};
  endfunction

  task automatic load_key(input logic [15:0] k);
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    tick();
    bus.key_valid = 1'b0;
    tick();
    tick();
  endtask

  int          acc_cyc [8];
  logic [15:0] pt;
  int          w;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    cyc           = 0;
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_in    = 16'h0;
    bus.in_valid  = 1'b0;
    bus.plain_in  = 16'h0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_key_ready", 32'(bus.key_ready), 1);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_keys_ok", 32'(bus.keys_ok), 0);
    check("rst_cipher", 32'(bus.cipher_out), 32'h0);
    #3 rst_n = 1'b1;
    tick();

    // Key expansion of 4AF5
    bus.key_valid = 1'b1;
    bus.key_in    = 16'h4AF5;
    tick();
    bus.key_valid = 1'b0;
    check("kexp1_keys_ok", 32'(bus.keys_ok), 0);
    check("kexp1_key_ready", 32'(bus.key_ready), 0);
    tick();
    check("kexp2_keys_ok", 32'(bus.keys_ok), 0);
    tick();
    check("kexp_done_keys_ok", 32'(bus.keys_ok), 1);
    check("key0", 32'(dut.key0_q), 32'h4AF5);
    check("key1", 32'(dut.key1_q), 32'hDD28);
    check("key2", 32'(dut.key2_q), 32'h87AF);
    check("ready_in_ready", 32'(bus.in_ready), 1);

    // Known-answer block
    bus.in_valid = 1'b1;
    bus.plain_in = 16'hD728;
    tick();
    bus.in_valid = 1'b0;
    check("calc_out_valid", 32'(bus.out_valid), 0);
    check("calc_in_ready", 32'(bus.in_ready), 0);
    check("calc_key_ready", 32'(bus.key_ready), 0);
    tick();
    check("kat_out_valid", 32'(bus.out_valid), 1);
    check("kat_cipher", 32'(bus.cipher_out), 32'h24EC);
    check("kat_keys_ok", 32'(bus.keys_ok), 1);

    // Backpressure with a second block waiting
    bus.in_valid = 1'b1;
    bus.plain_in = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_cipher", 32'(bus.cipher_out), 32'h24EC);
      check("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_drain_out_valid", 32'(bus.out_valid), 0);
    check("bp_drain_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_second_taken", 32'(bus.in_ready), 0);
    tick();
    check("bp_second_valid", 32'(bus.out_valid), 1);
    check("bp_second_cipher", 32'(bus.cipher_out), 32'(ref_enc(16'h1234, 16'h4AF5)));

    // Asynchronous reset in HOLD, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_keys_ok", 32'(bus.keys_ok), 0);
    check("arst_key_ready", 32'(bus.key_ready), 1);
    check("arst_in_ready", 32'(bus.in_ready), 0);
    check("arst_cipher", 32'(bus.cipher_out), 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // Key/block collision in READY
    load_key(16'h4AF5);
    check("col_pre_keys_ok", 32'(bus.keys_ok), 1);
    bus.key_valid = 1'b1;
    bus.key_in    = 16'hA73B;
    bus.in_valid  = 1'b1;
    bus.plain_in  = 16'h6F6B;
    #1;
    check("col_in_ready", 32'(bus.in_ready), 0);
    check("col_key_ready", 32'(bus.key_ready), 1);
    tick();
    bus.key_valid = 1'b0;
    check("col_kexp_keys_ok", 32'(bus.keys_ok), 0);
    check("col_kexp_in_ready", 32'(bus.in_ready), 0);
    tick();
    check("col_kexp2_in_ready", 32'(bus.in_ready), 0);
    tick();
    check("col_keys_ok", 32'(bus.keys_ok), 1);
    check("col_in_ready_after", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("col_out_valid", 32'(bus.out_valid), 1);
    check("col_cipher", 32'(bus.cipher_out), 32'(ref_enc(16'h6F6B, 16'hA73B)));
    bus.out_ready = 1'b1;
    tick();

    // Back-to-back blocks with out_ready tied high
    for (int i = 0; i < 8; i++) begin
      pt           = 16'($urandom);
      bus.plain_in = pt;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 10) begin
        tick();
        w++;
      end
      check("b2b_in_ready", 32'(bus.in_ready), 1);
      tick();
      acc_cyc[i]   = cyc;
      bus.in_valid = 1'b0;
      tick();
      check("b2b_out_valid", 32'(bus.out_valid), 1);
      check("b2b_cipher", 32'(bus.cipher_out), 32'(ref_enc(pt, 16'hA73B)));
      if (i > 0) check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 3);
    end
    bus.out_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
